// File: rtl/sonar_capture_ctrl_if.sv
// Handshake bundle between the SONAR capture sequencer, the top-level control
// logic and the counter/ADC datapath. The sequencer takes the master view.
interface sonar_capture_ctrl_if;
    logic       start;
    logic       abort;
    logic [5:0] cfg_div;
    logic [5:0] cnt_q;
    logic       cnt_resetn;
    logic       cnt_enable;
    logic       adc_convst;
    logic       adc_ack;
    logic [1:0] ch_sel;
    logic       sample_valid;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        input  start, abort, cfg_div, cnt_q, adc_ack,
        output cnt_resetn, cnt_enable, adc_convst, ch_sel, sample_valid, busy, done, err
    );

    modport slave (
        output start, abort, cfg_div, cnt_q, adc_ack,
        input  cnt_resetn, cnt_enable, adc_convst, ch_sel, sample_valid, busy, done, err
    );
endinterface

// File: rtl/sonar_capture_ctrl.sv
// SONAR capture sequencer: runs NUM_CH x BURST_LEN timed ADC conversions,
// stepping round-robin over the hydrophone channels.
// Optional ADC-acknowledge watchdog enabled by defining SONAR_CAPTURE_TIMEOUT_EN.
module sonar_capture_ctrl #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned TIMEOUT_CYC = 200
) (
    input logic                  clk,
    input logic                  resetn,
    sonar_capture_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        StIdle, StClear, StCount, StConvert, StWaitAck, StDone
    } state_t;

    localparam logic [1:0] LastCh    = 2'(NUM_CH - 1);
    localparam logic [7:0] LastRound = 8'(BURST_LEN - 1);

    if (NUM_CH < 1 || NUM_CH > 4) begin : g_bad_num_ch
        $error("NUM_CH out of range 1..4");
    end
    if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_burst_len
        $error("BURST_LEN out of range 1..256");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYC out of range 1..255");
    end

    state_t     state_q;
    logic [5:0] div_q;
    logic [1:0] ch_q;
    logic [7:0] round_q;
    logic       cnt_resetn_q;
    logic       adc_convst_q;
    logic       busy_q;
    logic       done_q;

    logic abort_now;
    logic ack_take;
    logic timeout;
    logic advance;
    logic last_sample;

`ifdef SONAR_CAPTURE_TIMEOUT_EN
    localparam logic [7:0] WdogLast = 8'(TIMEOUT_CYC - 1);
    logic [7:0] wdog_q;
    logic       err_q;
    assign timeout = (state_q == StWaitAck) && !bus.adc_ack && (wdog_q == WdogLast);
    assign bus.err = err_q;
`else
    assign timeout = 1'b0;
    assign bus.err = 1'b0;
`endif

    assign abort_now   = bus.abort && (state_q != StIdle);
    assign ack_take    = (state_q == StWaitAck) && bus.adc_ack;
    assign advance     = ack_take || timeout;
    assign last_sample = (ch_q == LastCh) && (round_q == LastRound);

    // Sequencer state, channel/round bookkeeping and registered strobes
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= StIdle;
            div_q        <= 6'd0;
            ch_q         <= 2'd0;
            round_q      <= 8'd0;
            cnt_resetn_q <= 1'b0;
            adc_convst_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SONAR_CAPTURE_TIMEOUT_EN
            wdog_q       <= 8'd0;
            err_q        <= 1'b0;
`endif
        end else begin
            adc_convst_q <= 1'b0;
            done_q       <= 1'b0;
            cnt_resetn_q <= 1'b1;
            if (abort_now) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (bus.start) begin
                            div_q        <= bus.cfg_div;
                            ch_q         <= 2'd0;
                            round_q      <= 8'd0;
                            cnt_resetn_q <= 1'b0;
                            busy_q       <= 1'b1;
                            state_q      <= StClear;
`ifdef SONAR_CAPTURE_TIMEOUT_EN
                            err_q        <= 1'b0;
`endif
                        end
                    end
                    StClear: state_q <= StCount;
                    StCount: begin
                        if (bus.cnt_q == div_q) begin
                            adc_convst_q <= 1'b1;
                            state_q      <= StConvert;
                        end
                    end
                    StConvert: begin
                        state_q <= StWaitAck;
`ifdef SONAR_CAPTURE_TIMEOUT_EN
                        wdog_q  <= 8'd0;
`endif
                    end
                    StWaitAck: begin
`ifdef SONAR_CAPTURE_TIMEOUT_EN
                        if (timeout) begin
                            err_q <= 1'b1;
                        end else if (!advance) begin
                            wdog_q <= wdog_q + 8'd1;
                        end
`endif
                        if (advance) begin
                            if (ch_q == LastCh) begin
                                ch_q    <= 2'd0;
                                round_q <= round_q + 8'd1;
                            end else begin
                                ch_q <= ch_q + 2'd1;
                            end
                            if (last_sample) begin
                                done_q  <= 1'b1;
                                state_q <= StDone;
                            end else begin
                                cnt_resetn_q <= 1'b0;
                                state_q      <= StClear;
                            end
                        end
                    end
                    StDone: begin
                        ch_q    <= 2'd0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Abort clears the counter in the same cycle it is seen
    assign bus.cnt_resetn   = cnt_resetn_q && !abort_now;
    assign bus.cnt_enable   = (state_q == StCount) && (bus.cnt_q != div_q);
    assign bus.adc_convst   = adc_convst_q;
    assign bus.ch_sel       = ch_q;
    assign bus.sample_valid = ack_take && !abort_now;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_sonar_capture_ctrl.sv
// Self-checking bench for sonar_capture_ctrl: counter and ADC behavioural models,
// scoreboard of expected (channel, cycle) samples and expected done cycle.
module tb_sonar_capture_ctrl;
    localparam int NumCh      = 4;
    localparam int BurstLen   = 2;
    localparam int TimeoutCyc = 10;

    typedef struct packed {
        logic [1:0] ch;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    sonar_capture_ctrl_if bus ();

    sonar_capture_ctrl #(
        .NUM_CH      (NumCh),
        .BURST_LEN   (BurstLen),
        .TIMEOUT_CYC (TimeoutCyc)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t q[$];
    int   exp_done = -1;
    bit   done_seen = 1'b0;
    bit   mon_en = 1'b0;
    bit   hold_ch2 = 1'b0;
    int   max_cnt = 0;
    logic [5:0] cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // External six-bit counter model
    always @(posedge clk) begin
        if (bus.cnt_resetn !== 1'b1) cnt <= 6'd0;
        else if (bus.cnt_enable === 1'b1) cnt <= cnt + 6'd1;
    end
    assign bus.cnt_q = cnt;

    // ADC model: ack one cycle after convst, optionally never for channel 2
    always @(posedge clk) begin
        if (!resetn) bus.adc_ack <= 1'b0;
        else bus.adc_ack <= (bus.adc_convst === 1'b1) && !(hold_ch2 && bus.ch_sel == 2'd2);
    end

    // Output monitor against the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.busy === 1'b1 && bus.cnt_resetn === 1'b1 && int'(bus.cnt_q) > max_cnt)
                max_cnt = int'(bus.cnt_q);
            if (bus.sample_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("sv_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sv_ch", 32'(bus.ch_sel), 32'(e.ch));
                    chk("sv_cyc", cyc, e.cyc);
                end
            end
            if (bus.done === 1'b1) begin
                done_seen = 1'b1;
                if (exp_done < 0) chk("done_unexpected", 32'd1, 32'd0);
                else chk("done_cyc", cyc, exp_done);
            end
        end
    end

    task automatic run_burst(input int div, input bit mid_change, input bit poke_start,
                             input bit withhold);
        int t;
        int i;
        bit skip;
        @(posedge clk);
        #1;
        bus.cfg_div = 6'(div);
        bus.start   = 1'b1;
        max_cnt     = 0;
        done_seen   = 1'b0;
        t = cyc;
        for (int r = 0; r < BurstLen; r++) begin
            for (int ch = 0; ch < NumCh; ch++) begin
                skip = withhold && (ch == 2);
                t += div + 3 + (skip ? TimeoutCyc : 1);
                if (!skip) q.push_back('{ch: 2'(ch), cyc: t});
            end
        end
        exp_done = t + 1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("err_cleared", 32'(bus.err), 32'd0);
        if (mid_change) begin
            repeat (6) @(posedge clk);
            #1 bus.cfg_div = 6'd63;
        end
        if (poke_start) begin
            repeat (3) @(posedge clk);
            #1 bus.start = 1'b1;
            @(posedge clk);
            #1 bus.start = 1'b0;
        end
        i = 0;
        while (!done_seen && i < 3000) begin
            @(posedge clk);
            i++;
        end
        if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
        #1;
        chk("busy_after_done", 32'(bus.busy), 32'd0);
        chk("ch_sel_after_done", 32'(bus.ch_sel), 32'd0);
        chk("cnt_resetn_idle", 32'(bus.cnt_resetn), 32'd1);
        chk("queue_empty", q.size(), 32'd0);
        chk("max_cnt", max_cnt, div);
`ifdef SONAR_CAPTURE_TIMEOUT_EN
        chk("err_end", 32'(bus.err), 32'(withhold));
`else
        chk("err_end", 32'(bus.err), 32'd0);
`endif
        exp_done = -1;
    endtask

    task automatic run_abort();
        int  t;
        bit  found;
        @(posedge clk);
        #1;
        bus.cfg_div = 6'd2;
        bus.start   = 1'b1;
        done_seen   = 1'b0;
        exp_done    = -1;
        t = cyc;
        for (int ch = 0; ch < 2; ch++) begin
            t += 2 + 4;
            q.push_back('{ch: 2'(ch), cyc: t});
        end
        @(posedge clk);
        #1 bus.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.adc_convst === 1'b1 && bus.ch_sel == 2'd2) found = 1'b1;
        end
        chk("abort_reached_ch2", 32'(found), 32'd1);
        @(posedge clk);
        #1 bus.abort = 1'b1;
        @(negedge clk);
        chk("abort_ack_high", 32'(bus.adc_ack), 32'd1);
        chk("abort_cnt_resetn", 32'(bus.cnt_resetn), 32'd0);
        chk("abort_no_sv", 32'(bus.sample_valid), 32'd0);
        @(posedge clk);
        #1 bus.abort = 1'b0;
        chk("abort_idle", 32'(bus.busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_queue_empty", q.size(), 32'd0);
        chk("abort_no_done", 32'(done_seen), 32'd0);
    endtask

    initial begin
        bus.start   = 1'b1;
        bus.abort   = 1'b0;
        bus.cfg_div = 6'd0;
        resetn      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_cnt_resetn", 32'(bus.cnt_resetn), 32'd0);
        chk("rst_cnt_enable", 32'(bus.cnt_enable), 32'd0);
        chk("rst_convst", 32'(bus.adc_convst), 32'd0);
        chk("rst_sv", 32'(bus.sample_valid), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_ch_sel", 32'(bus.ch_sel), 32'd0);
        resetn    = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_cnt_resetn", 32'(bus.cnt_resetn), 32'd1);
        chk("rel_busy", 32'(bus.busy), 32'd0);
        mon_en = 1'b1;

        run_burst(5, 1'b0, 1'b0, 1'b0);
        run_burst(0, 1'b1, 1'b1, 1'b0);
        run_abort();
        run_burst(0, 1'b0, 1'b0, 1'b0);
        run_burst(63, 1'b0, 1'b0, 1'b0);
`ifdef SONAR_CAPTURE_TIMEOUT_EN
        hold_ch2 = 1'b1;
        run_burst(1, 1'b0, 1'b0, 1'b1);
        hold_ch2 = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("err_sticky", 32'(bus.err), 32'd1);
        run_burst(3, 1'b0, 1'b0, 1'b0);
`endif
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sonar_capture_ctrl.md
# sonar_capture_ctrl

Sequencer for the SONAR front end's six-bit sample-period counter and the hydrophone ADC. On a start pulse it runs a burst of NUM_CH × BURST_LEN conversions. For each conversion it clears and enables the external six-bit counter for a programmable period, pulses the ADC convert strobe, waits for the ADC acknowledge, and steps round-robin across hydrophone channels. It sits between the SONAR top-level control logic and the counter/ADC datapath.

## Interface
- NUM_CH, 4: hydrophone channels per round; 1..4.
- BURST_LEN, 16: rounds per burst; 1..256.
- TIMEOUT_CYC, 200: maximum WAIT_ACK cycles; 1..255. Used only with SONAR_CAPTURE_TIMEOUT_EN.
- clk  in  1: system clock; all state changes on the rising edge.
- resetn  in  1: synchronous, active-low reset.
- start  in  1: one-cycle burst request; honoured only in IDLE.
- abort  in  1: synchronous burst cancel.
- cfg_div  in  6: terminal count for the period counter; latched at start.
- cnt_q  in  6: current value of the external six-bit counter.
- cnt_resetn  out  1: active-low clear to the counter.
- cnt_enable  out  1: count enable to the counter.
- adc_convst  out  1: one-cycle ADC conversion strobe.
- adc_ack  in  1: ADC conversion complete.
- ch_sel  out  2: active hydrophone channel.
- sample_valid  out  1: one-cycle pulse; the ADC result for ch_sel is valid.
- busy  out  1: high in every state except IDLE.
- done  out  1: one-cycle end-of-burst pulse.
- err  out  1: sticky timeout flag.

## Operation
- States: IDLE, CLEAR, COUNT, CONVERT, WAIT_ACK, DONE.
- IDLE: all strobes low, cnt_resetn=1, cnt_enable=0.
  - start=1: latch cfg_div into div_r, set ch_sel=0 and round=0, clear err, go to CLEAR.
- CLEAR: cnt_resetn=0 for exactly one cycle, then go to COUNT.
- COUNT: cnt_enable = (cnt_q != div_r), combinational.
  - When cnt_q == div_r, go to CONVERT. The counter holds at div_r.
- CONVERT: adc_convst=1 for exactly one cycle, then go to WAIT_ACK.
- WAIT_ACK: hold until adc_ack=1. On that cycle:
  - Pulse sample_valid with the current ch_sel.
  - If ch_sel == NUM_CH-1, wrap ch_sel to 0 and increment round; otherwise increment ch_sel.
  - If the last channel of round BURST_LEN-1 has completed, go to DONE; otherwise go to CLEAR.
- DONE: done=1 for one cycle, then go to IDLE. ch_sel returns to 0.
- abort=1 in any non-IDLE state: go to IDLE on the next edge.
  - cnt_resetn=0 during the abort cycle.
  - No done or sample_valid pulse.
  - abort has priority over adc_ack in the same cycle.
- start while busy is ignored. cfg_div changes mid-burst are ignored until the next start.
- div_r=0: COUNT lasts one cycle.
- adc_ack outside WAIT_ACK is ignored.

## Timing
- Reset (resetn=0 at an edge): state=IDLE, ch_sel=0, round=0, div_r=0, err=0, cnt_resetn=0, cnt_enable=0, adc_convst=0, sample_valid=0, busy=0, done=0.
  - cnt_resetn=0 only during reset; it is 1 in IDLE afterwards.
- Reset mid-burst aborts with no done pulse.
- start sampled at edge N: CLEAR in cycle N+1, first COUNT cycle N+2 with cnt_q=0.
- COUNT lasts div_r+1 cycles.
- Per-sample period = div_r + 3 + A cycles, where A ≥ 1 is the number of WAIT_ACK cycles.
  - Minimum period is div_r+4 cycles, when ack is high on the first WAIT_ACK cycle.
- sample_valid is asserted in the same cycle adc_ack is sampled high.
- done is asserted the cycle after the final sample_valid.
- busy drops the cycle after done.
- Burst length with immediate ack: 1 + NUM_CH·BURST_LEN·(div_r+4) + 1 cycles from start to done inclusive.

## Configuration
- SONAR_CAPTURE_TIMEOUT_EN defined:
  - An 8-bit watchdog counts WAIT_ACK cycles.
  - If TIMEOUT_CYC cycles elapse without adc_ack, set err=1 (sticky until next start or reset) and skip the sample: no sample_valid.
  - ch_sel/round advance exactly as for an acknowledged sample.
  - The watchdog clears on entry to WAIT_ACK.
- SONAR_CAPTURE_TIMEOUT_EN undefined:
  - WAIT_ACK waits indefinitely.
  - err is tied to 0.
  - No watchdog logic is present.

## Test plan
- Reset: resetn=0 for 2 cycles with start=1 -> all outputs at their reset values. Release -> IDLE, busy=0, cnt_resetn=1.
- NUM_CH=4, BURST_LEN=2, cfg_div=5, ack one cycle after each convst -> 8 sample_valid pulses with ch_sel 0,1,2,3,0,1,2,3, each 9 cycles apart. done 1 cycle after the last; COUNT never sees cnt_q above 5.
- cfg_div=0 with immediate ack -> period of 4 cycles. Change cfg_div to 63 mid-burst -> period unchanged.
- abort asserted on the same cycle as adc_ack during sample 3 -> no sample_valid, no done, IDLE next cycle. A following start restarts with ch_sel=0.
- start pulsed while busy -> ignored; sample count unchanged.
- With SONAR_CAPTURE_TIMEOUT_EN and TIMEOUT_CYC=10, ack withheld for channel 2 -> err=1 and no sample_valid for channel 2. The burst completes with done=1 and err stays 1 until the next start.
